// File: rtl/program_sequencer.sv
// program_sequencer: program counter with jumps, stalls and an optional 4-entry return stack.
// Define CALL_STACK_EN to build the call/ret stack; otherwise call and ret are ignored.
module program_sequencer (
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic [3:0] jmp_addr,
    input  logic       dont_jmp,
    input  logic       call,
    input  logic       ret,
    input  logic       hold,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic [7:0] from_PS,
    output logic       jump_flag,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);
    logic [7:0] target, pc_inc, top;
    logic       take_jmp, take_call, take_ret;
    assign target   = {jmp_addr, 4'h0};
    assign pc_inc   = pc + 8'd1;
    assign take_jmp = !hold && (jmp || (jmp_nz && !dont_jmp));
`ifdef CALL_STACK_EN
    logic [7:0] stack [4];
    logic [2:0] sp;
    logic       sel_ret;
    assign stack_empty = sp == 3'd0;
    assign stack_full  = sp == 3'd4;
    assign take_call   = !hold && !take_jmp && call;
    assign sel_ret     = !hold && !take_jmp && !call && ret;
    assign take_ret    = sel_ret && !stack_empty;
    assign top         = stack[sp[1:0] - 2'd1];
    // Storage is not reset: clearing sp alone makes old entries unreachable.
    always_ff @(posedge clk)
        if (!sync_reset && take_call && !stack_full) stack[sp[1:0]] <= pc_inc;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sp        <= 3'd0;
            stack_err <= 1'b0;
        end else begin
            if (take_call && !stack_full) sp <= sp + 3'd1;
            else if (take_ret) sp <= sp - 3'd1;
            stack_err <= stack_err || (take_call && stack_full) || (sel_ret && stack_empty);
        end
    end
`else
    wire unused_stack_inputs = &{1'b0, call, ret};
    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
    assign take_call   = 1'b0;
    assign take_ret    = 1'b0;
    assign top         = 8'h00;
`endif
    always_comb
        pm_addr = sync_reset ? 8'h00 :
                  hold ? pc :
                  (take_jmp || take_call) ? target :
                  take_ret ? top : pc_inc;
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc        <= 8'h00;
            jump_flag <= 1'b0;
        end else begin
            pc        <= pm_addr;
            jump_flag <= take_jmp || take_call || take_ret;
        end
    end
    assign from_PS = pc;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed spec scenarios plus random stimulus against a queue-based model.
module tb_program_sequencer;
    logic       clk = 1'b0;
    logic       sync_reset, jmp, jmp_nz, dont_jmp, call, ret, hold;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic       jump_flag, stack_full, stack_empty, stack_err;
    int         n_cmp = 0, n_bad = 0;
    logic [7:0] m_pc = 8'h00, m_nxt;
    logic       m_jf = 1'b0, m_err = 1'b0;
    logic [7:0] m_stk [$];

    program_sequencer dut (
        .clk(clk), .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr),
        .dont_jmp(dont_jmp), .call(call), .ret(ret), .hold(hold), .pm_addr(pm_addr), .pc(pc),
        .from_PS(from_PS), .jump_flag(jump_flag), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, h, j, jn, dz, c, rt, input logic [3:0] a);
        logic [7:0] tgt;
        logic       jf;
        @(negedge clk);
        {sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr} = {r, h, j, jn, dz, c, rt, a};
        tgt = {a, 4'h0};
        jf  = 1'b0;
        if (r) begin
            m_nxt = 8'h00;
            m_err = 1'b0;
            m_stk.delete();
        end else if (h) m_nxt = m_pc;
        else if (j || (jn && !dz)) begin
            m_nxt = tgt;
            jf = 1'b1;
        end
`ifdef CALL_STACK_EN
        else if (c) begin
            m_nxt = tgt;
            jf = 1'b1;
            if (m_stk.size() < 4) m_stk.push_back(m_pc + 8'd1);
            else m_err = 1'b1;
        end else if (rt) begin
            if (m_stk.size() > 0) begin
                m_nxt = m_stk.pop_back();
                jf = 1'b1;
            end else begin
                m_nxt = m_pc + 8'd1;
                m_err = 1'b1;
            end
        end
`endif
        else m_nxt = m_pc + 8'd1;
        #1 check("pm_addr", pm_addr, m_nxt);
        @(posedge clk);
        m_pc = m_nxt;
        m_jf = jf;
        #1;
        check("pc", pc, m_pc);
        check("from_PS", from_PS, m_pc);
        check("jump_flag", jump_flag, m_jf);
        check("stack_err", stack_err, m_err);
`ifdef CALL_STACK_EN
        check("stack_full", stack_full, m_stk.size() == 4);
        check("stack_empty", stack_empty, m_stk.size() == 0);
`else
        check("stack_full", stack_full, 1'b0);
        check("stack_empty", stack_empty, 1'b1);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    endtask

    task automatic go(input logic [3:0] a);
        step(0, 0, 1, 0, 0, 0, 0, a);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 1, 0, 1, 1, 4'hF);
            check("reset_pc", pc, 8'h00);
        end
        idle(1); check("rel_pc1", pc, 8'h01); check("rel_jf", jump_flag, 1'b0);
        idle(1); check("rel_pc2", pc, 8'h02);
        idle(1); check("rel_pc3", pc, 8'h03);
        go(4'h2); idle(10); check("at_2a", pc, 8'h2A);
        go(4'h7); check("jmp_pc", pc, 8'h70); check("jmp_jf", jump_flag, 1'b1);
        step(0, 0, 0, 1, 1, 0, 0, 4'h3); check("nz_fall", pc, 8'h71); check("nz_jf", jump_flag, 1'b0);
        step(0, 0, 0, 1, 0, 0, 0, 4'h3); check("nz_take", pc, 8'h30); check("nz_tjf", jump_flag, 1'b1);
        go(4'hF); idle(15); check("at_ff", pc, 8'hFF);
        idle(1); check("wrap", pc, 8'h00);
        go(4'h1); step(0, 1, 1, 0, 0, 1, 1, 4'h9); check("hold_pc", pc, 8'h10); check("hold_jf", jump_flag, 1'b0);
`ifdef CALL_STACK_EN
        go(4'h0); idle(5);
        for (int k = 1; k <= 4; k++) begin
            step(0, 0, 0, 0, 0, 1, 0, 4'(k));
            idle(5);
        end
        check("full", stack_full, 1'b1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h5); check("ovf_pc", pc, 8'h50); check("ovf_err", stack_err, 1'b1);
        for (int k = 3; k >= 0; k--) begin
            step(0, 0, 0, 0, 0, 0, 1, 4'h0);
            check("ret_pc", pc, 8'(k * 16 + 6));
        end
        check("empty", stack_empty, 1'b1);
        step(1, 0, 0, 0, 0, 0, 0, 4'h0);
        go(4'h2); step(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("unf_pc", pc, 8'h21); check("unf_jf", jump_flag, 1'b0); check("unf_err", stack_err, 1'b1);
        idle(3); check("err_held", stack_err, 1'b1);
        step(1, 0, 0, 0, 0, 0, 0, 4'h0); check("err_clr", stack_err, 1'b0);
`else
        go(4'h0); idle(3); step(0, 0, 0, 0, 0, 1, 0, 4'h9);
        check("nocs_pc", pc, 8'h04); check("nocs_empty", stack_empty, 1'b1); check("nocs_err", stack_err, 1'b0);
`endif
        for (int i = 0; i < 3000; i++)
            step($urandom_range(59) == 0, $urandom_range(7) == 0, $urandom_range(9) == 0,
                 $urandom_range(7) == 0, $urandom_range(1) == 0, $urandom_range(4) == 0,
                 $urandom_range(4) == 0, 4'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
